cm_stream_decoder: RTL and testbench
====================================

# cm_stream_decoder

Streaming inverse of the custom nibble-matrix encoder: accepts encoded bytes over a valid/ready handshake, multiplies each nibble by a loadable 4x4 GF(2) decode matrix, and buffers the decoded bytes in a first-word-fall-through FIFO. Sits on the receive side of the design, opposite the encoder datapath. Matrices are written through a small config port while the block is idle, then locked for streaming.

## Interface
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, 2..16.
- `clk`  in  1  system clock, all logic rising-edge.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `cfg_wr`  in  1  write strobe for one matrix row.
- `cfg_addr`  in  3  row select: 0-3 = low-nibble matrix rows 0-3, 4-7 = high-nibble matrix rows 0-3.
- `cfg_data`  in  4  row value; bit j set means output bit i includes input bit j.
- `cfg_lock`  in  1  pulse: CONFIG -> RUN.
- `cfg_unlock`  in  1  pulse: RUN -> DRAIN.
- `s_valid`  in  1  encoded byte valid.
- `s_ready`  out  1  decoder can accept.
- `s_data`  in  8  encoded byte.
- `m_valid`  out  1  decoded byte valid.
- `m_ready`  in  1  sink accepts.
- `m_data`  out  8  decoded byte.
- `run`  out  1  high in RUN state.
- `m_parity`  out  1  only with `CM_DEC_PARITY_EN`; see Configuration.

## Operation
- Decode: `m_bit[i] = ^(row_lo[i] & s_data[3:0])` for i = 0..3; `m_bit[4+i] = ^(row_hi[i] & s_data[7:4])`.
- Reset: all eight rows = identity (row i = 1<<i); FIFO empty; state CONFIG.
- FSM states CONFIG, RUN, DRAIN:
  - CONFIG: `cfg_wr` writes `cfg_data` to row `cfg_addr` at the edge; `s_ready`=0; `cfg_lock` -> RUN next cycle. `cfg_wr` with `cfg_lock` in the same cycle: the write takes effect, then RUN.
  - RUN: `s_ready = !full`; `cfg_wr` and `cfg_lock` are ignored; `cfg_unlock` -> DRAIN.
  - DRAIN: `s_ready`=0; FIFO continues to pop; -> CONFIG on the first edge with the FIFO empty. `cfg_wr`, `cfg_lock` and `cfg_unlock` are ignored.
  - `cfg_unlock` in CONFIG is ignored.
- Push occurs when `s_valid && s_ready`. The decoded value is computed combinationally and written into the FIFO.
- Pop occurs when `m_valid && m_ready`. `m_valid = !empty`. `m_data` is the FIFO head.
- Full FIFO with a simultaneous pop: `s_ready` stays 0 that cycle. There is no pass-through.
- Empty FIFO with a push: no bypass; data appears next cycle.
- Read and write pointers are `log2(FIFO_DEPTH)+1` bits and wrap modulo 2·DEPTH. The extra MSB distinguishes full from empty.
- `rst` mid-stream: FIFO contents are discarded, rows return to identity, state returns to CONFIG. Reset has priority over all inputs.

## Timing
- Reset values:
  - `s_ready`=0, `m_valid`=0, `m_data`=0x00, `run`=0, `m_parity`=0.
  - The FIFO storage is reset so that the head reads 0.
- Latency: a byte accepted at edge N gives `m_valid`=1 with its `m_data` in the cycle after edge N, provided the FIFO was empty.
- Throughput: one byte per cycle when `m_ready` is held high.
- `run` rises in the cycle after the `cfg_lock` edge. It falls in the cycle after the `cfg_unlock` edge.
- A row write is visible to decoding immediately after its edge. This can only matter in the next RUN.
- `m_data` and `m_valid` are held stable while `m_valid && !m_ready`.

## Configuration
- `CM_DEC_PARITY_EN` defined:
  - Adds a parity bit to each FIFO entry, so each entry is 9 bits wide.
  - Output `m_parity` = even parity (XOR) of the decoded byte at the FIFO head. It is valid with `m_valid`.
- `CM_DEC_PARITY_EN` undefined:
  - The `m_parity` port and its storage are absent.
  - FIFO entries are 8 bits.

## Test plan
- Reset, then `cfg_lock`, then push 0xA5 with `m_ready`=1 -> identity decode; `m_data`=0xA5 one cycle after acceptance.
- In CONFIG, write rows 0-3 = 0x1, 0x3, 0x7, 0xF, lock, push 0xA5 -> `m_data`=0xA3. With `CM_DEC_PARITY_EN`, `m_parity`=0.
- `m_ready`=0, `FIFO_DEPTH`=4, offer 5 bytes 0x10-0x14:
  - 0x10-0x13 accepted; `s_ready`=0 after the 4th.
  - Raising `m_ready` drains them in order; 0x14 is accepted the cycle after the first pop.
- Three bytes queued with `m_ready`=0, pulse `cfg_unlock`:
  - `run`=0 and `s_ready`=0.
  - A `cfg_wr` in DRAIN has no effect.
  - Releasing `m_ready` drains the three bytes, then the state is CONFIG.
- Assert `rst` for 1 cycle with two bytes queued and rows programmed -> `m_valid`=0 next cycle. After lock, 0x5A decodes to 0x5A (identity restored).
- Streaming 256 bytes 0x00-0xFF with random `m_ready` and random `s_valid` -> output sequence matches the decode model exactly. Pointer wrap-around is exercised at least 60 times.

Source files
------------

// File: rtl/cm_stream_decoder.sv
// Streaming nibble-matrix decoder: GF(2) 4x4 matrix per nibble, FWFT output FIFO.
// Optional feature macro: CM_DEC_PARITY_EN adds a stored even-parity bit and the m_parity output.
module cm_stream_decoder #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_wr,
    input  logic [2:0] cfg_addr,
    input  logic [3:0] cfg_data,
    input  logic       cfg_lock,
    input  logic       cfg_unlock,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       run
`ifdef CM_DEC_PARITY_EN
    ,
    output logic       m_parity
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
`ifdef CM_DEC_PARITY_EN
    localparam int unsigned EW = 9;
`else
    localparam int unsigned EW = 8;
`endif

    typedef enum logic [1:0] {
        ST_CONFIG = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t        r_state;
    logic [3:0]    r_row [8];
    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_dec;
    logic [EW-1:0] w_entry;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign s_ready = (r_state == ST_RUN) && !w_full;
    assign m_valid = !w_empty;
    assign run     = (r_state == ST_RUN);
    assign w_push  = s_valid && s_ready;
    assign w_pop   = m_valid && m_ready;
    assign m_data  = r_mem[r_rd_ptr[AW-1:0]][7:0];

    always_comb begin
        w_dec = '0;
        for (int i = 0; i < 4; i++) begin
            w_dec[i]     = ^(r_row[i] & s_data[3:0]);
            w_dec[4 + i] = ^(r_row[4 + i] & s_data[7:4]);
        end
    end

`ifdef CM_DEC_PARITY_EN
    assign w_entry  = {^w_dec, w_dec};
    assign m_parity = r_mem[r_rd_ptr[AW-1:0]][8];
`else
    assign w_entry  = w_dec;
`endif

    // Mode FSM and matrix rows; rows are only writable in CONFIG.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CONFIG;
            for (int i = 0; i < 8; i++) begin
                r_row[i] <= 4'(1 << (i % 4));
            end
        end else begin
            case (r_state)
                ST_CONFIG: begin
                    if (cfg_wr) begin
                        r_row[cfg_addr] <= cfg_data;
                    end
                    if (cfg_lock) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cfg_unlock) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_empty) begin
                        r_state <= ST_CONFIG;
                    end
                end
                default: r_state <= ST_CONFIG;
            endcase
        end
    end

    // Output FIFO; storage cleared on reset so the head reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
                r_wr_ptr                <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_cm_stream_decoder.sv
// Self-checking bench for cm_stream_decoder: decode vector table, handshake corners, random stream.
`timescale 1ns/1ps
module tb_cm_stream_decoder;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [3:0] cfg_data = '0;
    logic       cfg_lock = 1'b0;
    logic       cfg_unlock = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = '0;
    logic       m_ready = 1'b0;
    logic       s_ready;
    logic       m_valid;
    logic [7:0] m_data;
    logic       run;
`ifdef CM_DEC_PARITY_EN
    logic       m_parity;
`endif

    cm_stream_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_lock   (cfg_lock),
        .cfg_unlock (cfg_unlock),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .run        (run)
`ifdef CM_DEC_PARITY_EN
        ,
        .m_parity   (m_parity)
`endif
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] mrow [8];
    logic [7:0] exp_q [$];
    logic [7:0] sb_exp;

    typedef struct {
        logic [15:0] lo_rows;
        logic [15:0] hi_rows;
        logic [7:0]  din;
        logic [7:0]  dout;
    } vec_t;

    function automatic logic [7:0] model(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i]     = ^(mrow[i] & d[3:0]);
            r[4 + i] = ^(mrow[4 + i] & d[7:4]);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: handshakes sampled mid-cycle, inputs change just after posedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (s_valid && s_ready) exp_q.push_back(model(s_data));
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected: got 0x%0h, expected no output", m_data);
                end else begin
                    sb_exp = exp_q.pop_front();
                    chk("sb_data", 32'(m_data), 32'(sb_exp));
`ifdef CM_DEC_PARITY_EN
                    chk("sb_parity", 32'(m_parity), 32'(^sb_exp));
`endif
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) mrow[i] = 4'(1 << (i % 4));
    endtask

    task automatic cfg_write(input int addr, input logic [3:0] data, input bit effective);
        cfg_wr   = 1'b1;
        cfg_addr = 3'(addr);
        cfg_data = data;
        tick();
        cfg_wr = 1'b0;
        if (effective) mrow[addr] = data;
    endtask

    task automatic set_rows(input logic [15:0] lo, input logic [15:0] hi);
        for (int i = 0; i < 4; i++) begin
            cfg_write(i, lo[4*i +: 4], 1'b1);
            cfg_write(4 + i, hi[4*i +: 4], 1'b1);
        end
    endtask

    task automatic lock();
        cfg_lock = 1'b1;
        tick();
        cfg_lock = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int k = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && k < 50) begin
            tick();
            k++;
        end
        if (k == 50) chk("send_timeout", 32'(k), 32'(0));
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int k = 0;
        while (m_valid && k < budget) begin
            tick();
            k++;
        end
        if (k == budget) chk("drain_timeout", 32'(m_valid), 32'(0));
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{16'hF731, 16'h8421, 8'hA5, 8'hA3};
        vecs[1] = '{16'h0000, 16'h0000, 8'hFF, 8'h00};
        vecs[2] = '{16'h1248, 16'h8421, 8'h3C, 8'h33};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 8'h73, 8'hF0};
        vecs[4] = '{16'h8421, 16'hF731, 8'h5A, 8'h3A};
        vecs[5] = '{16'h8421, 16'h8421, 8'hC9, 8'hC9};

        // Reset values
        tick();
        do_reset();
        chk("rst_s_ready", 32'(s_ready), 32'(0));
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_m_data", 32'(m_data), 32'(0));
        chk("rst_run", 32'(run), 32'(0));
`ifdef CM_DEC_PARITY_EN
        chk("rst_m_parity", 32'(m_parity), 32'(0));
`endif

        // Identity decode and single-cycle latency
        lock();
        chk("lock_run", 32'(run), 32'(1));
        chk("lock_s_ready", 32'(s_ready), 32'(1));
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        tick();
        s_valid = 1'b0;
        chk("lat_m_valid", 32'(m_valid), 32'(1));
        chk("lat_m_data", 32'(m_data), 32'(8'hA5));
        tick();
        chk("lat_empty", 32'(m_valid), 32'(0));

        // Table of programmed matrices
        foreach (vecs[v]) begin
            do_reset();
            set_rows(vecs[v].lo_rows, vecs[v].hi_rows);
            chk("cfg_no_run", 32'(run), 32'(0));
            lock();
            m_ready = 1'b1;
            s_valid = 1'b1;
            s_data  = vecs[v].din;
            tick();
            s_valid = 1'b0;
            chk($sformatf("vec%0d_data", v), 32'(m_data), 32'(vecs[v].dout));
`ifdef CM_DEC_PARITY_EN
            chk($sformatf("vec%0d_parity", v), 32'(m_parity), 32'(^vecs[v].dout));
`endif
            tick();
        end

        // Full FIFO, then pop while full: no pass-through
        do_reset();
        lock();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h10 + i);
            chk($sformatf("fill_s_ready%0d", i), 32'(s_ready), (i < 4) ? 32'd1 : 32'd0);
            tick();
        end
        chk("full_s_ready", 32'(s_ready), 32'(0));
        chk("full_head", 32'(m_data), 32'(8'h10));
        m_ready = 1'b1;
        chk("full_pop_s_ready", 32'(s_ready), 32'(0));
        tick();
        chk("after_pop_s_ready", 32'(s_ready), 32'(1));
        chk("after_pop_head", 32'(m_data), 32'(8'h11));
        tick();
        s_valid = 1'b0;
        wait_empty(20);
        chk("full_sb_empty", 32'(exp_q.size()), 32'(0));

        // DRAIN: outputs drop, config write ignored, returns to CONFIG
        do_reset();
        lock();
        m_ready = 1'b0;
        send(8'h21);
        send(8'h22);
        send(8'h23);
        cfg_unlock = 1'b1;
        tick();
        cfg_unlock = 1'b0;
        chk("drain_run", 32'(run), 32'(0));
        chk("drain_s_ready", 32'(s_ready), 32'(0));
        chk("drain_m_valid", 32'(m_valid), 32'(1));
        cfg_write(1, 4'h0, 1'b0);
        m_ready = 1'b1;
        wait_empty(20);
        tick();
        cfg_write(0, 4'h3, 1'b1);
        lock();
        s_valid = 1'b1;
        s_data  = 8'h03;
        tick();
        s_valid = 1'b0;
        chk("post_drain_decode", 32'(m_data), 32'(8'h02));
        tick();

        // Mid-stream reset discards data and restores identity
        do_reset();
        cfg_write(0, 4'h3, 1'b1);
        lock();
        m_ready = 1'b0;
        send(8'h44);
        send(8'h55);
        do_reset();
        chk("mid_rst_m_valid", 32'(m_valid), 32'(0));
        chk("mid_rst_run", 32'(run), 32'(0));
        lock();
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h5A;
        tick();
        s_valid = 1'b0;
        chk("mid_rst_identity", 32'(m_data), 32'(8'h5A));
        tick();

        // Random-handshake stream of 256 bytes through a non-trivial matrix
        do_reset();
        set_rows(16'hF731, 16'h1248);
        lock();
        begin
            int  nb   = 0;
            int  nout = 0;
            int  cyc  = 0;
            bit  acc;
            bit  popd;
            while (nout < 256 && cyc < 5000) begin
                m_ready = 1'($urandom_range(0, 1));
                if (!s_valid && nb < 256 && $urandom_range(0, 3) != 0) begin
                    s_valid = 1'b1;
                    s_data  = 8'(nb);
                end
                acc  = s_valid && s_ready;
                popd = m_valid && m_ready;
                tick();
                if (acc) begin
                    nb++;
                    s_valid = 1'b0;
                end
                if (popd) nout++;
                cyc++;
            end
            chk("stream_count", 32'(nout), 32'd256);
            chk("stream_sb_empty", 32'(exp_q.size()), 32'(0));
        end

        m_ready = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
